// File: rtl/tft_pkg.sv
// Shared TFT constants: command opcodes, arbiter state encoding, client slot indices.
// No logic here; imported by the arbiter and its round-robin picker.
package tft_pkg;

  localparam logic [7:0] CASET = 8'h2A;
  localparam logic [7:0] PASET = 8'h2B;
  localparam logic [7:0] RAMWR = 8'h2C;

  localparam int CLI_INIT   = 0;
  localparam int CLI_MAZE   = 1;
  localparam int CLI_PLAYER = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: client 0 first when PRIO0, else first requester after owner.
// Zero latency, no backpressure; win_vld is low when nobody requests.
module rr_pick
  import tft_pkg::*;
#(
  parameter int N     = 3,
  parameter int PRIO0 = 1,
  parameter int IW    = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] owner,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          win_vld
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    if (PRIO0 != 0 && req[0]) begin
      win[0] = 1'b1;
      found  = 1'b1;
    end
    // Scan owner+1 .. owner+N so the previous grantee is considered last.
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(owner) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        win[cand] = 1'b1;
        win_idx   = cand;
      end
    end
    win_vld = found;
  end

endmodule

// File: rtl/tft_arbiter.sv
// Shares the TFT byte link among clients for whole transactions; grant 1 cycle after req.
// Strobes forward combinationally; c_busy holds off every non-owner and the owner while a byte is in flight.
module tft_arbiter
  import tft_pkg::*;
#(
  parameter int  N_CLIENTS = 3,
  parameter int  PRIO0     = 1,
  localparam int IW        = $clog2(N_CLIENTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CLIENTS-1:0]   req,
  output logic [N_CLIENTS-1:0]   grant,
  input  logic [N_CLIENTS-1:0]   c_transmit,
  input  logic [N_CLIENTS-1:0]   c_dc,
  input  logic [8*N_CLIENTS-1:0] c_data,
  output logic [N_CLIENTS-1:0]   c_busy,
  output logic                   tft_transmit,
  output logic                   tft_dc,
  output logic [7:0]             tft_data,
  input  logic                   tft_busy,
  output logic [IW-1:0]          owner
);

  arb_state_t           state, state_d;
  logic [N_CLIENTS-1:0] grant_d;
  logic [IW-1:0]        owner_d;
  logic                 inflight;

  logic [N_CLIENTS-1:0] pick_win;
  logic [IW-1:0]        pick_idx;
  logic                 pick_vld;

  rr_pick #(
    .N     (N_CLIENTS),
    .PRIO0 (PRIO0),
    .IW    (IW)
  ) u_pick (
    .req     (req),
    .owner   (owner),
    .win     (pick_win),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      owner    <= IW'(N_CLIENTS - 1);
      inflight <= 1'b0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      owner    <= owner_d;
      inflight <= tft_transmit;
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant;
    owner_d = owner;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_GRANT;
          grant_d = pick_win;
          owner_d = pick_idx;
        end
      end
      ST_GRANT: begin
        if ((req & grant) == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // inflight covers the cycle before the driver raises tft_busy for the last byte.
        if (!tft_busy && !inflight) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    tft_transmit = 1'b0;
    tft_dc       = 1'b0;
    tft_data     = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (grant[i]) begin
        tft_transmit = tft_transmit | c_transmit[i];
        tft_dc       = tft_dc | c_dc[i];
        tft_data     = tft_data | c_data[8*i +: 8];
      end
    end
  end

  assign c_busy = ~grant | {N_CLIENTS{tft_busy | inflight}};

endmodule

// File: tb/tb_tft_arbiter.sv
// Bench for tft_arbiter: round-robin and priority instances share stimulus; bytes checked via a scoreboard.
module tb_tft_arbiter;
  import tft_pkg::*;

  localparam int N = 3;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   c_transmit;
  logic [N-1:0]   c_dc;
  logic [8*N-1:0] c_data;
  logic           tft_busy;

  logic [N-1:0] g0, cb0, g1, cb1;
  logic         tx0, dc0, tx1, dc1;
  logic [7:0]   d0, d1;
  logic [1:0]   own0, own1;

  tft_arbiter #(.N_CLIENTS(N), .PRIO0(0)) u_rr (
    .clk(clk), .rst(rst), .req(req), .grant(g0), .c_transmit(c_transmit), .c_dc(c_dc),
    .c_data(c_data), .c_busy(cb0), .tft_transmit(tx0), .tft_dc(dc0), .tft_data(d0),
    .tft_busy(tft_busy), .owner(own0));

  tft_arbiter #(.N_CLIENTS(N), .PRIO0(1)) u_pr (
    .clk(clk), .rst(rst), .req(req), .grant(g1), .c_transmit(c_transmit), .c_dc(c_dc),
    .c_data(c_data), .c_busy(cb1), .tft_transmit(tx1), .tft_dc(dc1), .tft_data(d1),
    .tft_busy(tft_busy), .owner(own1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q[$];
  int         busy_len = 0;
  int         busy_cnt = 0;
  logic       xmit_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: scoreboard the rr instance's output mid-cycle, then model the driver's busy after the edge.
  task automatic tick();
    logic [8:0] e;
    @(negedge clk);
    if (tx0 === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: byte dc=%0b data=0x%02h emitted, expected none", dc0, d0);
      end else begin
        e = exp_q.pop_front();
        check("sb_byte", 32'({dc0, d0}), 32'(e));
      end
    end
    xmit_seen = (tx0 === 1'b1);
    @(posedge clk);
    #1;
    if (rst) busy_cnt = 0;
    else if (xmit_seen) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    tft_busy = (busy_cnt != 0);
    #1;
  endtask

  task automatic send(input int cl, input logic dc, input logic [7:0] d);
    int guard = 0;
    while (cb0[cl] && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_wait: client %0d c_busy got 1, expected 0", cl);
    end
    c_transmit[cl]      = 1'b1;
    c_dc[cl]            = dc;
    c_data[8*cl +: 8]   = d;
    exp_q.push_back({dc, d});
    tick();
    c_transmit[cl] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while ((g0 != 0 || g1 != 0) && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: grants got %b/%b, expected 000/000", name, g0, g1);
    end
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] g_rr;
    logic [2:0] g_pr;
    logic [1:0] o_rr;
    logic [1:0] o_pr;
  } arb_vec_t;

  arb_vec_t vt[10];
  int       ord[4];

  initial begin
    int guard;
    int w;
    vt[0] = '{3'b011, 3'b001, 3'b001, 2'd0, 2'd0};
    vt[1] = '{3'b011, 3'b010, 3'b001, 2'd1, 2'd0};
    vt[2] = '{3'b101, 3'b100, 3'b001, 2'd2, 2'd0};
    vt[3] = '{3'b110, 3'b010, 3'b010, 2'd1, 2'd1};
    vt[4] = '{3'b110, 3'b100, 3'b100, 2'd2, 2'd2};
    vt[5] = '{3'b001, 3'b001, 3'b001, 2'd0, 2'd0};
    vt[6] = '{3'b100, 3'b100, 3'b100, 2'd2, 2'd2};
    vt[7] = '{3'b010, 3'b010, 3'b010, 2'd1, 2'd1};
    vt[8] = '{3'b101, 3'b100, 3'b001, 2'd2, 2'd0};
    vt[9] = '{3'b111, 3'b001, 3'b001, 2'd0, 2'd0};
    ord   = '{0, 1, 2, 0};

    rst = 1'b1; req = '0; c_transmit = '0; c_dc = '0; c_data = '0; tft_busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_grant", 32'(g0), 32'(0));
    check("rst_busy", 32'(cb0), 32'(3'b111));
    check("rst_tx", 32'({tx0, dc0, d0}), 32'(0));
    check("rst_owner_rr", 32'(own0), 32'(2));
    check("rst_owner_pr", 32'(own1), 32'(2));

    // Arbitration table: each row is one short transaction from IDLE.
    for (int i = 0; i < 10; i++) begin
      req = vt[i].req;
      tick();
      check("tbl_grant_rr", 32'(g0), 32'(vt[i].g_rr));
      check("tbl_grant_pr", 32'(g1), 32'(vt[i].g_pr));
      check("tbl_owner_rr", 32'(own0), 32'(vt[i].o_rr));
      check("tbl_owner_pr", 32'(own1), 32'(vt[i].o_pr));
      req = '0;
      tick();
      tick();
      check("tbl_release", 32'({g0, g1}), 32'(0));
    end

    // Single client: player sends a column-address setup.
    busy_len = 0;
    req = 3'b001 << CLI_PLAYER;
    check("single_pre", 32'(g0), 32'(0));
    tick();
    check("single_grant", 32'(g0), 32'(3'b100));
    check("single_cbusy", 32'(cb0), 32'(3'b011));
    send(CLI_PLAYER, 1'b0, CASET);
    check("single_inflight0", 32'(cb0[2]), 32'(1));
    tick();
    check("single_free0", 32'(cb0[2]), 32'(0));
    send(CLI_PLAYER, 1'b1, 8'h00);
    check("single_inflight1", 32'(cb0[2]), 32'(1));
    tick();
    send(CLI_PLAYER, 1'b1, 8'h18);
    check("single_inflight2", 32'(cb0[2]), 32'(1));
    req = '0;
    tick();
    tick();
    check("single_release", 32'(g0), 32'(0));

    // Contention on the round-robin instance with every client requesting.
    busy_len = 2;
    req = 3'b111;
    for (int r = 0; r < 4; r++) begin
      guard = 0;
      while (g0 == 0 && guard < 30) begin tick(); guard++; end
      w = ord[r];
      check("cont_grant", 32'(g0), 32'(3'b001 << w));
      send(w, 1'b0, r[0] ? PASET : RAMWR);
      send(w, 1'b1, 8'(16 * w + r));
      if (r == 1) begin
        c_transmit[(w+1)%N] = 1'b1;
        c_data[8*((w+1)%N) +: 8] = 8'hFF;
        #1;
        check("cont_viol_tx", 32'(tx0), 32'(0));
        tick();
        c_transmit[(w+1)%N] = 1'b0;
      end
      req[w] = 1'b0;
      tick();
      check("cont_drain_hold", 32'(g0), 32'(3'b001 << w));
      req[w] = 1'b1;
      guard = 0;
      while (g0 != 0 && guard < 30) begin tick(); guard++; end
      check("cont_released", 32'(g0), 32'(0));
    end
    req = '0;
    wait_idle("cont_idle");

    // Priority: client 0 arrives mid-transaction of client 1, alongside client 2.
    req = 3'b001 << CLI_MAZE;
    tick();
    check("prio_first_pr", 32'(g1), 32'(3'b010));
    check("prio_first_rr", 32'(g0), 32'(3'b010));
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("prio_no_preempt", 32'(g1), 32'(3'b010));
    end
    req = 3'b101;
    guard = 0;
    while (g1 != 0 && guard < 30) begin tick(); guard++; end
    guard = 0;
    while (g1 == 0 && guard < 30) begin tick(); guard++; end
    check("prio_next_pr", 32'(g1), 32'(3'b001));
    check("prio_next_rr", 32'(g0), 32'(3'b100));
    req = '0;
    wait_idle("prio_idle");

    // Drain: last strobe and req drop in the same cycle, driver busy for 5 cycles.
    req = 3'b001 << CLI_INIT;
    c_data[15:8] = 8'h11;
    c_dc[1] = 1'b0;
    tick();
    check("drain_grant", 32'(g0), 32'(3'b001));
    busy_len = 0;
    send(CLI_INIT, 1'b0, CASET);
    busy_len = 5;
    guard = 0;
    while (cb0[0] && guard < 30) begin tick(); guard++; end
    c_transmit[0] = 1'b1; c_dc[0] = 1'b1; c_data[7:0] = 8'h55;
    exp_q.push_back({1'b1, 8'h55});
    req = 3'b010;
    for (int j = 1; j <= 8; j++) begin
      tick();
      c_transmit[0] = 1'b0;
      check("drain_grant_seq", 32'(g0), 32'(j <= 6 ? 3'b001 : (j == 7 ? 3'b000 : 3'b010)));
      check("drain_cbusy0", 32'(cb0[0]), 32'(j == 6 ? 0 : 1));
    end

    // Non-granted strobe while client 1 owns the link.
    c_c_viol: begin
      c_transmit[2] = 1'b1; c_dc[2] = 1'b1; c_data[23:16] = 8'hFF;
      #1;
      check("viol_tx", 32'(tx0), 32'(0));
      check("viol_data", 32'(d0), 32'(8'h11));
      check("viol_dc", 32'(dc0), 32'(0));
      tick();
      c_transmit[2] = 1'b0;
    end

    // Reset while client 1 is streaming pixels.
    busy_len = 0;
    send(CLI_MAZE, 1'b1, 8'hA5);
    guard = 0;
    while (cb0[1] && guard < 30) begin tick(); guard++; end
    c_transmit[1] = 1'b1; c_dc[1] = 1'b1; c_data[15:8] = 8'h5A;
    exp_q.push_back({1'b1, 8'h5A});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_grant", 32'({g0, g1}), 32'(0));
    check("mrst_tx", 32'({tx0, dc0, d0}), 32'(0));
    check("mrst_tx_pr", 32'({tx1, dc1, d1}), 32'(0));
    check("mrst_cbusy", 32'({cb0, cb1}), 32'(6'b111111));
    check("mrst_owner", 32'({own0, own1}), 32'(4'b1010));
    c_transmit[1] = 1'b0;
    req = 3'b011;
    tick();
    check("mrst_next_rr", 32'(g0), 32'(3'b001));
    check("mrst_next_pr", 32'(g1), 32'(3'b001));
    check("mrst_next_owner", 32'(own0), 32'(0));
    req = '0;
    tick();
    tick();
    check("idle_state", 32'(g0), 32'(0));

    c_transmit = 3'b111; c_dc = 3'b111; c_data = {3{8'hFF}};
    #1;
    check("idle_viol", 32'({tx0, dc0, d0}), 32'(0));
    tick();
    c_transmit = '0;
    tick();

    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
